// File: rtl/hydra_pkg.sv
// Shared types, constants and helpers for the hydra switch ingress path.
package hydra_pkg;

    localparam int PORT_NUM = 16;
    localparam int DW       = 16;

    typedef struct packed {
        logic [8:0] len;
        logic [2:0] prio;
        logic [3:0] dest;
    } ctrl_word_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOP  = 3'd1,
        ST_CTRL = 3'd2,
        ST_DATA = 3'd3,
        ST_EOP  = 3'd4,
        ST_GAP  = 3'd5
    } ingress_state_e;

    function automatic ctrl_word_t pack_ctrl(input logic [8:0] len,
                                             input logic [2:0] prio,
                                             input logic [3:0] dest);
        ctrl_word_t w;
        w.len  = len;
        w.prio = prio;
        w.dest = dest;
        return w;
    endfunction

endpackage

// File: rtl/hydra_ingress_framer.sv
// Per-port ingress framer: turns a descriptor plus its payload words into the
// hydra write protocol (sop, control word, data, eop) and counts sent/dropped packets.
module hydra_ingress_framer #(
    parameter int DW      = hydra_pkg::DW,
    parameter int LEN_W   = 9,
    parameter int MAX_LEN = 511,
    parameter int IFG     = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   desc_vld,
    output logic                                   desc_rdy,
    input  logic [LEN_W-1:0]                       desc_len,
    input  logic [2:0]                             desc_prio,
    input  logic [$clog2(hydra_pkg::PORT_NUM)-1:0] desc_dest,
    input  logic                                   pl_vld,
    output logic                                   pl_rdy,
    input  logic [DW-1:0]                          pl_data,
    input  logic                                   pause,
    output logic                                   wr_sop,
    output logic                                   wr_eop,
    output logic                                   wr_vld,
    output logic [DW-1:0]                          wr_data,
    output logic [15:0]                            pkt_cnt,
    output logic [15:0]                            drop_cnt
);
    import hydra_pkg::*;

    ingress_state_e   state_r, state_s;
    logic [LEN_W-1:0] rem_r, rem_s;
    logic [3:0]       gap_r, gap_s;
    ctrl_word_t       ctrl_r, ctrl_s;
    logic             sop_s, eop_s, vld_s;
    logic [DW-1:0]    data_s;
    logic [15:0]      pkt_s, drop_s;
    logic             desc_hs_s, pl_hs_s, len_ok_s;

    // pause only gates the start of a packet; payload is taken during CTRL as
    // well so the first word follows the control word without a bubble
    assign desc_rdy  = (state_r == ST_IDLE) && !pause;
    assign pl_rdy    = ((state_r == ST_CTRL) || (state_r == ST_DATA)) && (rem_r != {LEN_W{1'b0}});
    assign desc_hs_s = desc_vld && desc_rdy;
    assign pl_hs_s   = pl_vld && pl_rdy;
    assign len_ok_s  = (desc_len != {LEN_W{1'b0}}) && (32'(desc_len) <= MAX_LEN);

    // Next-state and next-output decode
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        gap_s   = gap_r;
        ctrl_s  = ctrl_r;
        sop_s   = 1'b0;
        eop_s   = 1'b0;
        vld_s   = 1'b0;
        data_s  = wr_data;
        pkt_s   = pkt_cnt;
        drop_s  = drop_cnt;
        case (state_r)
            ST_IDLE: begin
                if (desc_hs_s && !len_ok_s) begin
                    drop_s = drop_cnt + 16'd1;
                end else if (desc_hs_s) begin
                    ctrl_s  = pack_ctrl(9'(desc_len), desc_prio, desc_dest);
                    rem_s   = desc_len;
                    sop_s   = 1'b1;
                    state_s = ST_SOP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SOP: begin
                vld_s   = 1'b1;
                data_s  = DW'(ctrl_r);
                state_s = ST_CTRL;
            end
            ST_CTRL, ST_DATA: begin
                if (pl_hs_s) begin
                    vld_s   = 1'b1;
                    data_s  = pl_data;
                    rem_s   = rem_r - LEN_W'(1);
                    state_s = (rem_r == LEN_W'(1)) ? ST_EOP : ST_DATA;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_EOP: begin
                eop_s = 1'b1;
                pkt_s = pkt_cnt + 16'd1;
                if (IFG == 0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_s   = 4'(IFG);
                    state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_s = gap_r - 4'd1;
                if (gap_r <= 4'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered protocol outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rem_r    <= {LEN_W{1'b0}};
            gap_r    <= 4'd0;
            ctrl_r   <= pack_ctrl(9'd0, 3'd0, 4'd0);
            wr_sop   <= 1'b0;
            wr_eop   <= 1'b0;
            wr_vld   <= 1'b0;
            wr_data  <= {DW{1'b0}};
            pkt_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            state_r  <= state_s;
            rem_r    <= rem_s;
            gap_r    <= gap_s;
            ctrl_r   <= ctrl_s;
            wr_sop   <= sop_s;
            wr_eop   <= eop_s;
            wr_vld   <= vld_s;
            wr_data  <= data_s;
            pkt_cnt  <= pkt_s;
            drop_cnt <= drop_s;
        end
    end

endmodule
